alu_arbiter: RTL

//  Shares the single ALU (result-mux datapath, 8 ops) between two requesters:
//  req0 = execute path, req1 = address/PC-update path. Round-robin grant, latches

---
 rtl/alu_arbiter_if.sv | 65 ++++++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response signals for alu_arbiter
//
// Purpose: groups the two requester channels, the ALU drive/return and the
//          tagged response channel into one bundle.
// Modports:
//   slave  - the arbiter: takes requests, drives the ALU, returns responses
//   master - the environment: requesters, ALU and response consumer
// Signals:
//   req0_valid/req0_ready/req0_a/req0_b/req0_ctrl  execute-path requester
//   req1_valid/req1_ready/req1_a/req1_b/req1_ctrl  address/PC-update requester
//   alu_a/alu_b/alu_control                        operands and code to the ALU
//   alu_result/alu_flags                           combinational ALU return (NZCV)
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flags/rsp_err  response channel

interface alu_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;

    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_control;
    logic [WIDTH-1:0]  alu_result;
    logic [3:0]        alu_flags;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose: grants one of two requesters (round-robin on contention), latches
//          its operands, drives the ALU for a single EXEC cycle, registers the
//          result/flags and returns them on a tagged valid/ready response.
//          Codes with any bit above bit 2 set are illegal: the ALU then sees
//          code 0 and the response carries rsp_err=1 with zero result/flags.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of alu_arbiter_if (requests, ALU, response)

module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic              prio;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic              op_id;
    logic              op_illegal;

    logic              grant0;
    logic              grant1;
    logic              ready0;
    logic              ready1;

    logic              rsp_id_q;
    logic [WIDTH-1:0]  rsp_result_q;
    logic [3:0]        rsp_flags_q;
    logic              rsp_err_q;

    // Lone requester always wins; on contention prio picks, so the two
    // grants are mutually exclusive by construction.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);
    end

    assign op_illegal = |op_ctrl[CTRL_W-1:3];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ready0 || ready1) state_nx = S_EXEC;
            S_EXEC:  state_nx = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready0          = 1'b0;
        ready1          = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_control = '0;
        bus.rsp_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is handed over
                // on an edge that will discard it.
                ready0 = grant0 && !reset;
                ready1 = grant1 && !reset;
            end
            S_EXEC: begin
                bus.alu_a       = op_a;
                bus.alu_b       = op_b;
                bus.alu_control = op_illegal ? '0 : op_ctrl;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    // Operand latch, arbitration priority and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prio         <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_ctrl      <= '0;
            op_id        <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (ready0 || ready1) begin
                op_a    <= ready1 ? bus.req1_a    : bus.req0_a;
                op_b    <= ready1 ? bus.req1_b    : bus.req0_b;
                op_ctrl <= ready1 ? bus.req1_ctrl : bus.req0_ctrl;
                op_id   <= ready1;
                prio    <= !ready1;
            end
            if (state == S_EXEC) begin
                rsp_id_q     <= op_id;
                rsp_err_q    <= op_illegal;
                rsp_result_q <= op_illegal ? '0 : bus.alu_result;
                rsp_flags_q  <= op_illegal ? '0 : bus.alu_flags;
            end
        end
    end

    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
